raster_engine: RTL and testbench

Downstream consumer of the command processor. Takes one decoded drawing command per cmd_ready pulse and rasterizes it into an internal 8x8 one-bit framebuffer, one step per clock. Exposes a row read port for the display/output stage, plus busy, done and drop status.

---
 rtl/raster_engine_if.sv | 27 ++
 rtl/raster_engine.sv | 203 ++++++++++++++++++++
 tb/tb_raster_engine.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/raster_engine_if.sv
// Command, read-port and status bundle between the command processor / display
// stage (master) and the raster engine (slave).
interface raster_engine_if;
    logic [1:0] in_cmd;
    logic [2:0] in_x1;
    logic [2:0] in_y1;
    logic [2:0] in_x2;
    logic [2:0] in_y2;
    logic [2:0] in_width;
    logic [2:0] in_height;
    logic       cmd_ready;
    logic [2:0] rd_row;
    logic [7:0] rd_data;
    logic       busy;
    logic       done;
    logic       cmd_dropped;

    modport master (
        output in_cmd, in_x1, in_y1, in_x2, in_y2, in_width, in_height, cmd_ready, rd_row,
        input  rd_data, busy, done, cmd_dropped
    );

    modport slave (
        input  in_cmd, in_x1, in_y1, in_x2, in_y2, in_width, in_height, cmd_ready, rd_row,
        output rd_data, busy, done, cmd_dropped
    );
endinterface

// File: rtl/raster_engine.sv
// 8x8 one-bit rasterizer: PIXEL / CLEAR / RECT / LINE, one framebuffer write per clock.
// Define RASTER_XOR_EN to make PIXEL, RECT and LINE toggle bits instead of setting them.
module raster_engine (
    input  logic           clk,
    input  logic           rst,
    raster_engine_if.slave bus
);
    typedef enum logic [2:0] {IDLE, PIXEL, CLEAR, RECT, LINE} state_t;

    state_t            state_q, state_d;
    logic [2:0]        x_q, x_d, y_q, y_d;
    logic [2:0]        x2_q, x2_d, y2_q, y2_d;
    logic [2:0]        dx_q, dx_d, dy_q, dy_d;
    logic              sx_q, sx_d, sy_q, sy_d;
    logic signed [4:0] err_q, err_d;
    logic [2:0]        row_end_q, row_end_d;
    logic [7:0]        col_mask_q, col_mask_d;
    logic              done_q, done_d, drop_q, drop_d;
    logic [7:0]        fb_q [8];

    // Rectangle extents use 4-bit sums so they clip at 7 instead of wrapping.
    logic [3:0] x_sum, y_sum;
    logic [2:0] x_end, y_end;
    logic [7:0] rect_mask;
    assign x_sum     = {1'b0, bus.in_x1} + {1'b0, bus.in_width};
    assign y_sum     = {1'b0, bus.in_y1} + {1'b0, bus.in_height};
    assign x_end     = x_sum[3] ? 3'd7 : x_sum[2:0];
    assign y_end     = y_sum[3] ? 3'd7 : y_sum[2:0];
    assign rect_mask = (8'hFF << bus.in_x1) & (8'hFF >> (3'd7 - x_end));

    logic [2:0] abs_dx, abs_dy;
    assign abs_dx = (bus.in_x2 >= bus.in_x1) ? bus.in_x2 - bus.in_x1 : bus.in_x1 - bus.in_x2;
    assign abs_dy = (bus.in_y2 >= bus.in_y1) ? bus.in_y2 - bus.in_y1 : bus.in_y1 - bus.in_y2;

    logic signed [5:0] e2, dx_s6, dy_s6;
    logic              step_x, step_y;
    assign e2     = {err_q, 1'b0};
    assign dx_s6  = {3'b000, dx_q};
    assign dy_s6  = {3'b000, dy_q};
    assign step_x = e2 > -dy_s6;
    assign step_y = e2 < dx_s6;

    logic       wr_en, wr_clear;
    logic [2:0] wr_row;
    logic [7:0] wr_mask, wr_data, row_cur;

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        x2_d       = x2_q;
        y2_d       = y2_q;
        dx_d       = dx_q;
        dy_d       = dy_q;
        sx_d       = sx_q;
        sy_d       = sy_q;
        err_d      = err_q;
        row_end_d  = row_end_q;
        col_mask_d = col_mask_q;
        done_d     = 1'b0;
        drop_d     = bus.cmd_ready && (state_q != IDLE);
        wr_en      = 1'b0;
        wr_clear   = 1'b0;
        wr_row     = y_q;
        wr_mask    = 8'd1 << x_q;
        case (state_q)
            IDLE: begin
                if (bus.cmd_ready) begin
                    case (bus.in_cmd)
                        2'b01: begin
                            if (bus.in_x1 == 3'd7 && bus.in_y1 == 3'd7) begin
                                state_d = CLEAR;
                                y_d     = 3'd0;
                            end else begin
                                state_d = PIXEL;
                                x_d     = bus.in_x1;
                                y_d     = bus.in_y1;
                            end
                        end
                        2'b10: begin
                            state_d = LINE;
                            x_d     = bus.in_x1;
                            y_d     = bus.in_y1;
                            x2_d    = bus.in_x2;
                            y2_d    = bus.in_y2;
                            dx_d    = abs_dx;
                            dy_d    = abs_dy;
                            sx_d    = bus.in_x2 < bus.in_x1;
                            sy_d    = bus.in_y2 < bus.in_y1;
                            err_d   = $signed({2'b00, abs_dx}) - $signed({2'b00, abs_dy});
                        end
                        2'b11: begin
                            state_d    = RECT;
                            y_d        = bus.in_y1;
                            row_end_d  = y_end;
                            col_mask_d = rect_mask;
                        end
                        default: ;
                    endcase
                end
            end
            PIXEL: begin
                wr_en   = 1'b1;
                state_d = IDLE;
                done_d  = 1'b1;
            end
            CLEAR: begin
                wr_en    = 1'b1;
                wr_clear = 1'b1;
                if (y_q == 3'd7) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    y_d = y_q + 3'd1;
                end
            end
            RECT: begin
                wr_en   = 1'b1;
                wr_mask = col_mask_q;
                if (y_q == row_end_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    y_d = y_q + 3'd1;
                end
            end
            LINE: begin
                wr_en = 1'b1;
                if (x_q == x2_q && y_q == y2_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    // Both error updates are decided from the same e2 snapshot.
                    if (step_x) begin
                        err_d = err_d - $signed({2'b00, dy_q});
                        x_d   = sx_q ? x_q - 3'd1 : x_q + 3'd1;
                    end
                    if (step_y) begin
                        err_d = err_d + $signed({2'b00, dx_q});
                        y_d   = sy_q ? y_q - 3'd1 : y_q + 3'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        row_cur = fb_q[wr_row];
        if (wr_clear) begin
            wr_data = 8'h00;
        end else begin
`ifdef RASTER_XOR_EN
            wr_data = row_cur ^ wr_mask;
`else
            wr_data = row_cur | wr_mask;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            x_q        <= '0;
            y_q        <= '0;
            x2_q       <= '0;
            y2_q       <= '0;
            dx_q       <= '0;
            dy_q       <= '0;
            sx_q       <= 1'b0;
            sy_q       <= 1'b0;
            err_q      <= '0;
            row_end_q  <= '0;
            col_mask_q <= '0;
            done_q     <= 1'b0;
            drop_q     <= 1'b0;
            for (int r = 0; r < 8; r++) begin
                fb_q[r] <= 8'h00;
            end
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            x2_q       <= x2_d;
            y2_q       <= y2_d;
            dx_q       <= dx_d;
            dy_q       <= dy_d;
            sx_q       <= sx_d;
            sy_q       <= sy_d;
            err_q      <= err_d;
            row_end_q  <= row_end_d;
            col_mask_q <= col_mask_d;
            done_q     <= done_d;
            drop_q     <= drop_d;
            if (wr_en) begin
                fb_q[wr_row] <= wr_data;
            end
        end
    end

    assign bus.rd_data     = fb_q[bus.rd_row];
    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = done_q;
    assign bus.cmd_dropped = drop_q;
endmodule

// File: tb/tb_raster_engine.sv
// Scoreboard bench for raster_engine: stimulus queues expected done/drop/row events,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_raster_engine;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    raster_engine_if bus ();

    raster_engine dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef enum int {K_DONE, K_DROP, K_ROW} kind_t;
    typedef struct {
        kind_t kind;
        int    row;
        int    val;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   errors   = 0;
    int   busy_cnt = 0;
    bit   rd_valid = 1'b0;

    task automatic expect_item(input kind_t k, input int actual, input string what);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s: unexpected event, got %0d, required nothing", what, actual);
            return;
        end
        e = sb.pop_front();
        if (e.kind != k) begin
            errors++;
            $display("FAIL %s: got %s event, required %s event", what, k.name(), e.kind.name());
        end else if (e.val != actual) begin
            errors++;
            $display("FAIL %s row%0d: got 0x%0h, required 0x%0h", what, e.row, actual, e.val);
        end else begin
            $display("ok   %s row%0d: 0x%0h", what, e.row, actual);
        end
    endtask

    task automatic check_eq(input string what, input int actual, input int required);
        checks++;
        if (actual != required) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", what, actual, required);
        end else begin
            $display("ok   %s: %0d", what, actual);
        end
    endtask

    // Monitor: done value is the number of busy cycles observed for that command.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                busy_cnt = 0;
            end else begin
                if (bus.done) begin
                    expect_item(K_DONE, busy_cnt, "done_steps");
                    busy_cnt = 0;
                end
                if (bus.cmd_dropped) expect_item(K_DROP, 1, "cmd_dropped");
                if (rd_valid) expect_item(K_ROW, int'(bus.rd_data), "rd_data");
                if (bus.busy) busy_cnt++;
            end
        end
    end

    task automatic issue(input logic [1:0] c, input logic [2:0] x1, input logic [2:0] y1,
                         input logic [2:0] x2, input logic [2:0] y2,
                         input logic [2:0] w, input logic [2:0] h);
        @(posedge clk);
        #1;
        bus.in_cmd    = c;
        bus.in_x1     = x1;
        bus.in_y1     = y1;
        bus.in_x2     = x2;
        bus.in_y2     = y2;
        bus.in_width  = w;
        bus.in_height = h;
        bus.cmd_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.cmd_ready = 1'b0;
    endtask

    task automatic exp_done(input int steps);
        sb.push_back('{K_DONE, 0, steps});
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (bus.busy) begin
            checks++;
            errors++;
            $display("FAIL busy_timeout: got busy=1 after %0d cycles, required busy=0", n);
        end
    endtask

    task automatic read_row(input logic [2:0] r, input int v);
        sb.push_back('{K_ROW, int'(r), v});
        bus.rd_row = r;
        rd_valid   = 1'b1;
        @(posedge clk);
        #1;
        rd_valid = 1'b0;
    endtask

    task automatic read_all(input int v);
        for (int r = 0; r < 8; r++) read_row(3'(r), v);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of test, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst           = 1'b1;
        bus.in_cmd    = 2'b00;
        bus.in_x1     = 3'd0;
        bus.in_y1     = 3'd0;
        bus.in_x2     = 3'd0;
        bus.in_y2     = 3'd0;
        bus.in_width  = 3'd0;
        bus.in_height = 3'd0;
        bus.cmd_ready = 1'b0;
        bus.rd_row    = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        check_eq("reset_busy", int'(bus.busy), 0);
        check_eq("reset_done", int'(bus.done), 0);
        read_all(8'h00);

        issue(2'b00, 3'd1, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0);
        check_eq("nop_busy", int'(bus.busy), 0);
        repeat (2) @(posedge clk);
        #1;

        exp_done(1);
        issue(2'b01, 3'd3, 3'd5, 3'd0, 3'd0, 3'd0, 3'd0);
        wait_idle();
        for (int r = 0; r < 8; r++) read_row(3'(r), (r == 5) ? 8'h08 : 8'h00);

        exp_done(2);
        issue(2'b11, 3'd6, 3'd6, 3'd0, 3'd0, 3'd3, 3'd3);
        wait_idle();
        read_row(3'd0, 8'h00);
        read_row(3'd1, 8'h00);
        read_row(3'd5, 8'h08);
        read_row(3'd6, 8'hC0);
        read_row(3'd7, 8'hC0);

        exp_done(8);
        issue(2'b10, 3'd0, 3'd0, 3'd7, 3'd3, 3'd0, 3'd0);
        wait_idle();
        read_row(3'd0, 8'h03);
        read_row(3'd1, 8'h0C);
        read_row(3'd2, 8'h30);
        read_row(3'd3, 8'hC0);
        read_row(3'd4, 8'h00);

        exp_done(1);
        issue(2'b10, 3'd5, 3'd5, 3'd5, 3'd5, 3'd0, 3'd0);
        wait_idle();
        read_row(3'd5, 8'h28);

        // Right-to-left, bottom-to-top line: pixels (7,7),(6,7),(5,6),(4,6).
        exp_done(4);
        issue(2'b10, 3'd7, 3'd7, 3'd4, 3'd6, 3'd0, 3'd0);
        wait_idle();
        read_row(3'd6, 8'hF0);
`ifdef RASTER_XOR_EN
        read_row(3'd7, 8'h00);
`else
        read_row(3'd7, 8'hC0);
`endif

        exp_done(8);
        issue(2'b01, 3'd7, 3'd7, 3'd0, 3'd0, 3'd0, 3'd0);
        wait_idle();
        read_all(8'h00);

        exp_done(8);
        issue(2'b11, 3'd0, 3'd0, 3'd0, 3'd0, 3'd7, 3'd7);
        wait_idle();
        read_all(8'hFF);

        // CLEAR with a PIXEL strobe landing mid-clear: dropped, clear still completes.
        sb.push_back('{K_DROP, 0, 1});
        exp_done(8);
        issue(2'b01, 3'd7, 3'd7, 3'd0, 3'd0, 3'd0, 3'd0);
        issue(2'b01, 3'd1, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0);
        wait_idle();
        read_all(8'h00);

        exp_done(1);
        issue(2'b01, 3'd2, 3'd2, 3'd0, 3'd0, 3'd0, 3'd0);
        wait_idle();
        read_row(3'd2, 8'h04);
        issue(2'b10, 3'd0, 3'd0, 3'd7, 3'd7, 3'd0, 3'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("rst_mid_line_busy", int'(bus.busy), 0);
        check_eq("rst_mid_line_done", int'(bus.done), 0);
        read_all(8'h00);

`ifdef RASTER_XOR_EN
        exp_done(8);
        issue(2'b11, 3'd0, 3'd0, 3'd0, 3'd0, 3'd7, 3'd7);
        wait_idle();
        read_all(8'hFF);
        exp_done(8);
        issue(2'b11, 3'd0, 3'd0, 3'd0, 3'd0, 3'd7, 3'd7);
        wait_idle();
        read_all(8'h00);
`endif

        // Second strobe lands in the done cycle of the first: accepted, not dropped.
        exp_done(1);
        exp_done(1);
        issue(2'b01, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0);
        issue(2'b11, 3'd1, 3'd1, 3'd0, 3'd0, 3'd1, 3'd0);
        wait_idle();
        read_row(3'd0, 8'h01);
        read_row(3'd1, 8'h06);

        repeat (3) @(posedge clk);
        check_eq("scoreboard_left", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
